// File: rtl/gravity_scheduler.sv
// Gravity scheduler for the Tetris game FSM.
// It counts 60 Hz frame ticks against a level-dependent gravity period and
// issues one-row drop requests and piece lock requests through req/ack
// handshakes. It also handles soft drop, hard drop, lock delay and pause, so
// the game FSM never has to count time.
module gravity_scheduler #(
  parameter int unsigned SOFT_FRAMES = 2,   // frames per row while soft_drop is held (1..63)
  parameter int unsigned LOCK_FRAMES = 30   // frame ticks a landed piece waits before a lock request (1..63)
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       frame_tick,
  input  logic [3:0] level,
  input  logic       soft_drop,
  input  logic       hard_drop,
  input  logic       pause,
  input  logic       spawn,
  input  logic       landed,
  input  logic       drop_ack,
  input  logic       lock_ack,
  output logic       drop_req,
  output logic       lock_req,
  output logic       active,
  output logic [5:0] period
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FALL,
    S_DROP_WAIT,
    S_LOCK_DELAY,
    S_LOCK_WAIT
  } state_e;

  localparam logic [6:0] SOFT_P = 7'(SOFT_FRAMES);
  localparam logic [6:0] LOCK_P = 7'(LOCK_FRAMES);

  state_e     state_q;
  logic [5:0] frame_cnt_q;
  logic [5:0] lock_cnt_q;
  logic [3:0] level_q;
  logic       soft_q;
  logic       drop_req_q;
  logic       lock_req_q;
  logic       active_q;

  logic [5:0] period_d;
  logic       frame_due;
  logic       lock_due;

  // Capture level and soft_drop so that period is derived from registered values only.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples its pre-edge value regardless of the order of the statements.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      level_q <= 4'd0;
      soft_q  <= 1'b0;
    end else begin
      level_q <= level;
      soft_q  <= soft_drop;
    end
  end

  // Gravity period lookup: soft drop overrides the level table, which saturates at level 9.
  // NOTE: period_d gets a default before the case, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    period_d = 6'd6;
    if (soft_q) begin
      period_d = SOFT_P[5:0];
    end else begin
      case (level_q)
        4'd0:    period_d = 6'd48;
        4'd1:    period_d = 6'd43;
        4'd2:    period_d = 6'd38;
        4'd3:    period_d = 6'd33;
        4'd4:    period_d = 6'd28;
        4'd5:    period_d = 6'd23;
        4'd6:    period_d = 6'd18;
        4'd7:    period_d = 6'd13;
        4'd8:    period_d = 6'd8;
        default: period_d = 6'd6;
      endcase
    end
  end

  // The >= comparisons never wrap: if the period shrinks mid-count, the next tick fires.
  assign frame_due = ({1'b0, frame_cnt_q} + 7'd1) >= {1'b0, period_d};
  assign lock_due  = ({1'b0, lock_cnt_q} + 7'd1) >= LOCK_P;

  // Descent FSM. While pause is high, only the ack-driven exits of the wait states can fire.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      frame_cnt_q <= 6'd0;
      lock_cnt_q  <= 6'd0;
      drop_req_q  <= 1'b0;
      lock_req_q  <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (spawn && !pause) begin
            state_q     <= S_FALL;
            frame_cnt_q <= 6'd0;
            active_q    <= 1'b1;
          end
        end

        S_FALL: begin
          if (!pause) begin
            if (hard_drop) begin
              state_q    <= S_LOCK_WAIT;
              lock_req_q <= 1'b1;
            end else if (landed) begin
              state_q    <= S_LOCK_DELAY;
              lock_cnt_q <= 6'd0;
            end else if (frame_tick) begin
              if (frame_due) begin
                state_q     <= S_DROP_WAIT;
                drop_req_q  <= 1'b1;
                frame_cnt_q <= 6'd0;
              end else begin
                frame_cnt_q <= frame_cnt_q + 6'd1;
              end
            end
          end
        end

        S_DROP_WAIT: begin
          // Ticks arriving here are discarded. The handshake completes even while paused.
          if (drop_ack) begin
            drop_req_q <= 1'b0;
            if (landed) begin
              state_q    <= S_LOCK_DELAY;
              lock_cnt_q <= 6'd0;
            end else begin
              state_q     <= S_FALL;
              frame_cnt_q <= 6'd0;
            end
          end
        end

        S_LOCK_DELAY: begin
          if (!pause) begin
            if (hard_drop) begin
              state_q    <= S_LOCK_WAIT;
              lock_req_q <= 1'b1;
            end else if (!landed) begin
              state_q     <= S_FALL;
              frame_cnt_q <= 6'd0;
            end else if (frame_tick) begin
              if (lock_due) begin
                state_q    <= S_LOCK_WAIT;
                lock_req_q <= 1'b1;
              end else begin
                lock_cnt_q <= lock_cnt_q + 6'd1;
              end
            end
          end
        end

        S_LOCK_WAIT: begin
          if (lock_ack) begin
            state_q    <= S_IDLE;
            lock_req_q <= 1'b0;
            active_q   <= 1'b0;
          end
        end

        default: begin
          state_q    <= S_IDLE;
          drop_req_q <= 1'b0;
          lock_req_q <= 1'b0;
          active_q   <= 1'b0;
        end
      endcase
    end
  end

  assign drop_req = drop_req_q;
  assign lock_req = lock_req_q;
  assign active   = active_q;
  assign period   = period_d;

endmodule

// File: tb/tb_gravity_scheduler.sv
// Directed testbench for gravity_scheduler.
// Inputs are driven right after each falling edge. Outputs are sampled on the
// next falling edge, which comes after the rising edge that acted on them.
module tb_gravity_scheduler;

  logic       clk = 1'b0;
  logic       resetn;
  logic       frame_tick;
  logic [3:0] level;
  logic       soft_drop;
  logic       hard_drop;
  logic       pause;
  logic       spawn;
  logic       landed;
  logic       drop_ack;
  logic       lock_ack;
  logic       drop_req;
  logic       lock_req;
  logic       active;
  logic [5:0] period;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gravity_scheduler #(
    .SOFT_FRAMES(2),
    .LOCK_FRAMES(30)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .frame_tick(frame_tick),
    .level     (level),
    .soft_drop (soft_drop),
    .hard_drop (hard_drop),
    .pause     (pause),
    .spawn     (spawn),
    .landed    (landed),
    .drop_ack  (drop_ack),
    .lock_ack  (lock_ack),
    .drop_req  (drop_req),
    .lock_req  (lock_req),
    .active    (active),
    .period    (period)
  );

  // Drive one input pulse for exactly one rising edge.
  task automatic tick();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
  endtask

  task automatic pulse_spawn();
    spawn = 1'b1;
    @(negedge clk);
    spawn = 1'b0;
  endtask

  task automatic pulse_drop_ack(input logic landed_v);
    landed   = landed_v;
    drop_ack = 1'b1;
    @(negedge clk);
    drop_ack = 1'b0;
  endtask

  task automatic pulse_lock_ack();
    lock_ack = 1'b1;
    @(negedge clk);
    lock_ack = 1'b0;
  endtask

  // Run n ticks and return the number of ticks after which a request was visible.
  task automatic quiet_ticks(input int n, output int reqs);
    reqs = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (drop_req !== 1'b0 || lock_req !== 1'b0) reqs++;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    idle_cycle();
    checks++;
    if (drop_req !== 1'b0 || lock_req !== 1'b0 || active !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: drop_req=%b lock_req=%b active=%b, want 0 0 0", drop_req, lock_req, active);
    end
    checks++;
    if (period !== 6'd48) begin
      errors++;
      $display("FAIL reset_period: got %0d want 48", period);
    end
  endtask

  // Level 0 gravity: the drop request must appear on exactly the 48th tick.
  task automatic test_level0_fall();
    int reqs;
    pulse_spawn();
    checks++;
    if (active !== 1'b1) begin
      errors++;
      $display("FAIL spawn_active: got %b want 1", active);
    end
    quiet_ticks(47, reqs);
    checks++;
    if (reqs != 0) begin
      errors++;
      $display("FAIL l0_early_req: got %0d early requests, want 0", reqs);
    end
    tick();
    checks++;
    if (drop_req !== 1'b1 || lock_req !== 1'b0) begin
      errors++;
      $display("FAIL l0_drop_on_48: drop_req=%b lock_req=%b, want 1 0", drop_req, lock_req);
    end
    // Ticks are discarded while a drop is outstanding, and the request is held.
    tick();
    checks++;
    if (drop_req !== 1'b1) begin
      errors++;
      $display("FAIL drop_req_held: got %b want 1", drop_req);
    end
    pulse_drop_ack(1'b0);
    checks++;
    if (drop_req !== 1'b0 || active !== 1'b1) begin
      errors++;
      $display("FAIL drop_ack_clear: drop_req=%b active=%b, want 0 1", drop_req, active);
    end
  endtask

  // Period table, soft drop override, and a mid-count switch to a shorter period.
  task automatic test_period();
    int reqs;
    level = 4'd12;
    idle_cycle();
    checks++;
    if (period !== 6'd6) begin
      errors++;
      $display("FAIL period_level12: got %0d want 6", period);
    end
    soft_drop = 1'b1;
    idle_cycle();
    checks++;
    if (period !== 6'd2) begin
      errors++;
      $display("FAIL period_soft: got %0d want 2", period);
    end
    for (int r = 0; r < 2; r++) begin
      tick();
      checks++;
      if (drop_req !== 1'b0) begin
        errors++;
        $display("FAIL soft_tick1_row%0d: drop_req=%b want 0", r, drop_req);
      end
      tick();
      checks++;
      if (drop_req !== 1'b1) begin
        errors++;
        $display("FAIL soft_tick2_row%0d: drop_req=%b want 1", r, drop_req);
      end
      pulse_drop_ack(1'b0);
    end
    soft_drop = 1'b0;
    level     = 4'd0;
    idle_cycle();
    quiet_ticks(20, reqs);
    checks++;
    if (reqs != 0 || period !== 6'd48) begin
      errors++;
      $display("FAIL l0_count20: reqs=%0d period=%0d, want 0 48", reqs, period);
    end
    level = 4'd9;
    idle_cycle();
    checks++;
    if (period !== 6'd6) begin
      errors++;
      $display("FAIL period_level9: got %0d want 6", period);
    end
    tick();
    checks++;
    if (drop_req !== 1'b1) begin
      errors++;
      $display("FAIL level_up_fire: drop_req=%b want 1", drop_req);
    end
  endtask

  // Landing after a drop, the lock delay, and the lock handshake back to IDLE.
  task automatic test_lock_delay();
    int reqs;
    pulse_drop_ack(1'b1);
    checks++;
    if (drop_req !== 1'b0 || lock_req !== 1'b0 || active !== 1'b1) begin
      errors++;
      $display("FAIL landed_ack: drop_req=%b lock_req=%b active=%b, want 0 0 1", drop_req, lock_req, active);
    end
    quiet_ticks(29, reqs);
    checks++;
    if (reqs != 0) begin
      errors++;
      $display("FAIL lock_early: got %0d early requests, want 0", reqs);
    end
    tick();
    checks++;
    if (lock_req !== 1'b1 || drop_req !== 1'b0) begin
      errors++;
      $display("FAIL lock_on_30: lock_req=%b drop_req=%b, want 1 0", lock_req, drop_req);
    end
    pulse_lock_ack();
    checks++;
    if (lock_req !== 1'b0 || active !== 1'b0) begin
      errors++;
      $display("FAIL lock_ack_idle: lock_req=%b active=%b, want 0 0", lock_req, active);
    end
    landed = 1'b0;
    idle_cycle();
  endtask

  // The piece slides off a ledge mid lock delay and gravity restarts from zero.
  task automatic test_slide_off();
    int reqs;
    level = 4'd0;
    idle_cycle();
    pulse_spawn();
    quiet_ticks(47, reqs);
    tick();
    checks++;
    if (reqs != 0 || drop_req !== 1'b1) begin
      errors++;
      $display("FAIL slide_first_drop: early=%0d drop_req=%b, want 0 1", reqs, drop_req);
    end
    pulse_drop_ack(1'b1);
    quiet_ticks(15, reqs);
    landed = 1'b0;
    idle_cycle();
    quiet_ticks(47, reqs);
    checks++;
    if (reqs != 0) begin
      errors++;
      $display("FAIL slide_no_req: got %0d requests, want 0", reqs);
    end
    tick();
    checks++;
    if (drop_req !== 1'b1 || lock_req !== 1'b0) begin
      errors++;
      $display("FAIL slide_drop_48: drop_req=%b lock_req=%b, want 1 0", drop_req, lock_req);
    end
    pulse_drop_ack(1'b0);
  endtask

  // Hard drop from FALL, spawn ignored during LOCK_WAIT, stray acks ignored in IDLE.
  task automatic test_hard_drop();
    int reqs;
    quiet_ticks(10, reqs);
    hard_drop = 1'b1;
    @(negedge clk);
    hard_drop = 1'b0;
    checks++;
    if (lock_req !== 1'b1 || drop_req !== 1'b0) begin
      errors++;
      $display("FAIL hard_drop_lock: lock_req=%b drop_req=%b, want 1 0", lock_req, drop_req);
    end
    pulse_spawn();
    checks++;
    if (lock_req !== 1'b1 || active !== 1'b1) begin
      errors++;
      $display("FAIL spawn_in_lock_wait: lock_req=%b active=%b, want 1 1", lock_req, active);
    end
    pulse_lock_ack();
    pulse_drop_ack(1'b0);
    pulse_lock_ack();
    checks++;
    if (lock_req !== 1'b0 || drop_req !== 1'b0 || active !== 1'b0) begin
      errors++;
      $display("FAIL idle_stray_acks: lock_req=%b drop_req=%b active=%b, want 0 0 0", lock_req, drop_req, active);
    end
  endtask

  // Pause freezes counting mid-fall, drops hard_drop, and still honours an ack.
  task automatic test_pause();
    int reqs;
    pulse_spawn();
    quiet_ticks(40, reqs);
    pause = 1'b1;
    quiet_ticks(50, reqs);
    hard_drop = 1'b1;
    @(negedge clk);
    hard_drop = 1'b0;
    if (drop_req !== 1'b0 || lock_req !== 1'b0) reqs++;
    begin
      int more;
      quiet_ticks(50, more);
      reqs += more;
    end
    checks++;
    if (reqs != 0) begin
      errors++;
      $display("FAIL paused_reqs: got %0d requests, want 0", reqs);
    end
    pause = 1'b0;
    idle_cycle();
    quiet_ticks(7, reqs);
    checks++;
    if (reqs != 0) begin
      errors++;
      $display("FAIL unpause_early: got %0d requests, want 0", reqs);
    end
    tick();
    checks++;
    if (drop_req !== 1'b1) begin
      errors++;
      $display("FAIL unpause_drop_8: drop_req=%b want 1", drop_req);
    end
    pause = 1'b1;
    pulse_drop_ack(1'b0);
    checks++;
    if (drop_req !== 1'b0) begin
      errors++;
      $display("FAIL paused_ack: drop_req=%b want 0", drop_req);
    end
    quiet_ticks(60, reqs);
    checks++;
    if (reqs != 0) begin
      errors++;
      $display("FAIL paused_after_ack: got %0d requests, want 0", reqs);
    end
    pause = 1'b0;
    idle_cycle();
  endtask

  // Reset while a drop request is outstanding aborts it.
  task automatic test_reset_mid();
    int reqs;
    quiet_ticks(47, reqs);
    tick();
    checks++;
    if (reqs != 0 || drop_req !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_drop: early=%0d drop_req=%b, want 0 1", reqs, drop_req);
    end
    resetn = 1'b0;
    @(negedge clk);
    checks++;
    if (drop_req !== 1'b0 || lock_req !== 1'b0 || active !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: drop_req=%b lock_req=%b active=%b, want 0 0 0", drop_req, lock_req, active);
    end
    resetn = 1'b1;
    idle_cycle();
    pulse_spawn();
    checks++;
    if (active !== 1'b1) begin
      errors++;
      $display("FAIL respawn_after_reset: active=%b want 1", active);
    end
  endtask

  initial begin
    resetn     = 1'b0;
    frame_tick = 1'b0;
    level      = 4'd0;
    soft_drop  = 1'b0;
    hard_drop  = 1'b0;
    pause      = 1'b0;
    spawn      = 1'b0;
    landed     = 1'b0;
    drop_ack   = 1'b0;
    lock_ack   = 1'b0;
    @(negedge clk);
    test_reset();
    test_level0_fall();
    test_period();
    test_lock_delay();
    test_slide_off();
    test_hard_drop();
    test_pause();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gravity_scheduler.md
Name: gravity_scheduler

Overview:
- Sequences piece descent for the Tetris game FSM.
- Consumes a 1-cycle 60 Hz frame tick and counts frames against a level-dependent gravity period.
- Issues drop and lock requests to the game FSM through req/ack handshakes.
- Handles soft drop, hard drop, pause and lock delay, so the game FSM never counts time itself.

Parameters:
- SOFT_FRAMES, 2, frames per row while soft_drop is held (1..63).
- LOCK_FRAMES, 30, frame ticks a landed piece waits before a lock request (1..63).

Ports:
- clk  in  1  system clock, 50 MHz
- resetn  in  1  synchronous active-low reset
- frame_tick  in  1  1-cycle pulse, 60 Hz frame strobe
- level  in  4  current game level, 0..15
- soft_drop  in  1  level-sensitive; selects SOFT_FRAMES period
- hard_drop  in  1  1-cycle pulse; request immediate lock
- pause  in  1  freezes all counting and state transitions
- spawn  in  1  1-cycle pulse; new piece placed, start falling
- landed  in  1  level-sensitive; piece cannot move down
- drop_ack  in  1  game FSM has performed the one-row drop
- lock_ack  in  1  game FSM has locked the piece
- drop_req  out  1  request a one-row drop; held until acked
- lock_req  out  1  request a piece lock; held until acked
- active  out  1  high when state != IDLE
- period  out  6  current gravity period in frames (debug/HUD)

Behaviour:
- Reset: resetn is synchronous, active-low; clock is clk. At reset, state=IDLE, frame_cnt=0, lock_cnt=0, drop_req=0, lock_req=0, active=0. Reset mid-operation aborts any pending request; outputs are 0 after the next edge.
- All outputs are registered.
- period is combinational from registered inputs:
  - soft_drop=1: period=SOFT_FRAMES.
  - otherwise, by level 0..9: 48, 43, 38, 33, 28, 23, 18, 13, 8, 6.
  - level >= 9 saturates at 6.
- States: IDLE, FALL, DROP_WAIT, LOCK_DELAY, LOCK_WAIT.
- IDLE:
  - spawn -> FALL, frame_cnt=0.
  - All other inputs are ignored.
- FALL, priority order:
  - hard_drop -> LOCK_WAIT, lock_req=1.
  - landed -> LOCK_DELAY, lock_cnt=0.
  - frame_tick: if frame_cnt+1 >= period -> DROP_WAIT, drop_req=1, frame_cnt=0; else frame_cnt+1.
  - The >= compare means a mid-count switch to a shorter period (level up, soft_drop press) fires on the next tick. It never wraps.
- DROP_WAIT:
  - drop_req stays high until drop_ack is sampled.
  - On drop_ack: drop_req=0 on the same edge. landed=1 -> LOCK_DELAY, lock_cnt=0; else -> FALL.
  - frame_tick is discarded (not accumulated).
  - hard_drop is ignored.
- LOCK_DELAY:
  - hard_drop -> LOCK_WAIT, lock_req=1.
  - landed=0 (piece slid off ledge) -> FALL, frame_cnt=0.
  - frame_tick: if lock_cnt+1 >= LOCK_FRAMES -> LOCK_WAIT, lock_req=1; else lock_cnt+1.
- LOCK_WAIT:
  - lock_req stays high until lock_ack. On lock_ack -> IDLE, lock_req=0.
  - All other inputs are ignored.
- spawn outside IDLE is ignored.
- drop_ack/lock_ack arriving while the matching req is low are ignored.
- pause=1 freezes state, frame_cnt, lock_cnt and held reqs.
  - frame_tick, hard_drop and spawn are dropped.
  - Acks are still honoured, so an in-flight handshake completes.
- drop_req and lock_req are never high simultaneously.
- Latency: the frame_tick that completes a count raises drop_req/lock_req on that same clk edge; outputs are visible the next cycle.

Test Plan:
- Reset, spawn, level=0, 48 frame_ticks, ack each drop_req with landed=0 -> drop_req rises on exactly the 48th tick; period=48; active=1 after spawn.
- level=12 -> period=6. Same level with soft_drop=1 -> period=2, drop_req every 2nd tick. Raise level 0->9 with frame_cnt=20 -> drop_req on next tick.
- drop_ack with landed=1 -> LOCK_DELAY. 30 ticks -> lock_req on 30th. lock_ack -> IDLE, active=0, lock_req=0 next cycle.
- In LOCK_DELAY at lock_cnt=15, drop landed to 0 -> return to FALL. Next drop_req after 48 ticks (level 0); lock_req never asserted.
- hard_drop in FALL at frame_cnt=10 -> lock_req next cycle, no drop_req. Spawn during LOCK_WAIT ignored.
- pause=1 for 100 ticks mid-FALL (frame_cnt=40) -> no reqs; unpause -> drop_req after 8 more ticks. resetn=0 while drop_req=1 -> drop_req=0, IDLE.
